// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared coin codes, state encoding and credit limits for the coin front-end
package vm_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_RELEASE = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    localparam int CREDIT_MAX     = 20;
    localparam int RELEASE_THRESH = 15;

    // Rupee value of a coin code; anything that is not a real coin is worth nothing.
    function automatic logic [4:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  return 5'd5;
            COIN_10: return 5'd10;
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// rtl/coin_acceptor_if.sv - sensor, vend and coin-output bundle between the slot hardware and the vending FSM
interface coin_acceptor_if;

    logic       sens_5;
    logic       sens_10;
    logic       vend_req;
    logic [1:0] coin_code;
    logic       coin_reject;
    logic       busy;
    logic [4:0] credit;

    modport master (
        output sens_5, sens_10, vend_req,
        input  coin_code, coin_reject, busy, credit
    );

    modport slave (
        input  sens_5, sens_10, vend_req,
        output coin_code, coin_reject, busy, credit
    );

endinterface

// File: rtl/coin_acceptor_debounce.sv
// rtl/coin_acceptor_debounce.sv - synchroniser, stability filter and rising-edge pulse for one slot sensor
module coin_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sens,
    output logic coin_evt
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic          filt;
    logic          filt_d;
    logic          armed;
    logic [CW-1:0] chg_cnt;
    logic [CW-1:0] low_cnt;

    // Two-flop synchroniser for the asynchronous sensor level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= sens;
            sync2 <= sync1;
        end
    end

    // Filtered level flips once DEBOUNCE_CYC consecutive samples disagree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt    <= 1'b0;
            chg_cnt <= '0;
        end else if (sync2 == filt) begin
            chg_cnt <= '0;
        end else if (chg_cnt == CNT_LAST) begin
            filt    <= sync2;
            chg_cnt <= '0;
        end else begin
            chg_cnt <= chg_cnt + 1'b1;
        end
    end

    // Arm only after a confirmed low level, so a sensor held high through reset never counts as a coin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed   <= 1'b0;
            low_cnt <= '0;
        end else if (!armed) begin
            if (sync2) begin
                low_cnt <= '0;
            end else if (low_cnt == CNT_LAST) begin
                armed <= 1'b1;
            end else begin
                low_cnt <= low_cnt + 1'b1;
            end
        end
    end

    // Previous filtered level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_d <= 1'b0;
        end else begin
            filt_d <= filt;
        end
    end

    assign coin_evt = filt & ~filt_d & armed;

endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - debounced coin front-end with escrow FIFO and back-to-back release sequencer
module coin_acceptor
    import vm_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT_CYC  = 1000,
    parameter int GAP_CYC      = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    coin_acceptor_if.slave bus
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYC - 1);
    localparam logic [AW:0]   FIFO_FULL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [4:0]    THRESH     = 5'(RELEASE_THRESH);
    localparam logic [5:0]    CAP        = 6'(CREDIT_MAX);

    logic [1:0]    rst_pipe;
    logic          rst_n_int;
    logic          evt_5;
    logic          evt_10;
    state_t        state;
    state_t        state_nx;
    logic          accept;
    logic          reject;
    logic          pop;
    logic          busy_c;
    logic [1:0]    push_code;
    logic [5:0]    credit_sum;
    logic [1:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic [TW-1:0] timer;
    logic [GW-1:0] gap_cnt;
    logic [4:0]    credit;
    logic [1:0]    coin_code_q;
    logic          coin_reject_q;

    // Reset asserts immediately and releases two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_n_int = rst_pipe[1];

    coin_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_5 (
        .clk      (clk),
        .rst_n    (rst_n_int),
        .sens     (bus.sens_5),
        .coin_evt (evt_5)
    );

    coin_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_10 (
        .clk      (clk),
        .rst_n    (rst_n_int),
        .sens     (bus.sens_10),
        .coin_evt (evt_10)
    );

    assign full       = (count == FIFO_FULL);
    assign push_code  = evt_10 ? COIN_10 : COIN_5;
    assign credit_sum = {1'b0, credit} + {1'b0, coin_value(push_code)};

    // State register.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; a coin accepted alongside vend_req is already in the FIFO when RELEASE starts.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (accept) state_nx = ST_COLLECT;
            ST_COLLECT: if (credit >= THRESH || bus.vend_req || timer == TIMER_LAST) state_nx = ST_RELEASE;
            ST_RELEASE: if (count <= (AW + 1)'(1)) state_nx = ST_GAP;
            ST_GAP:     if (gap_cnt == GAP_LAST) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Per-state controls: accept/reject of coin events, FIFO pop and busy.
    always_comb begin
        accept = 1'b0;
        pop    = 1'b0;
        busy_c = 1'b0;
        case (state)
            ST_IDLE, ST_COLLECT: accept = (evt_5 ^ evt_10) && !full && (credit < THRESH);
            ST_RELEASE: begin
                pop    = (count != '0);
                busy_c = 1'b1;
            end
            ST_GAP:     busy_c = 1'b1;
            default:    ;
        endcase
        reject = (evt_5 | evt_10) & ~accept;
    end

    // Escrow storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_mem[wr_ptr] <= push_code;
        end
    end

    // Escrow pointers and occupancy; push and pop never coincide since they belong to different states.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count + 1'b1;
        end else if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
        end
    end

    // Collect timer restarts on every accepted coin and only runs while staying in COLLECT.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            timer <= '0;
        end else if (state_nx != ST_COLLECT || accept) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Counts the forced idle cycles after a release burst.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            gap_cnt <= '0;
        end else if (state == ST_GAP) begin
            gap_cnt <= gap_cnt + 1'b1;
        end else begin
            gap_cnt <= '0;
        end
    end

    // Running escrow value; cleared as the burst hands over to GAP.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            credit <= '0;
        end else if (state == ST_RELEASE && state_nx == ST_GAP) begin
            credit <= '0;
        end else if (accept) begin
            credit <= (credit_sum > CAP) ? CAP[4:0] : credit_sum[4:0];
        end
    end

    // Registered coin output and reject pulse.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            coin_code_q   <= COIN_NONE;
            coin_reject_q <= 1'b0;
        end else begin
            coin_code_q   <= pop ? fifo_mem[rd_ptr] : COIN_NONE;
            coin_reject_q <= reject;
        end
    end

    assign bus.coin_code   = coin_code_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.busy        = busy_c;
    assign bus.credit      = credit;

endmodule
